// File: rtl/cr_xp10_decomp_pkg.sv
// Shared HTF decompressor types: first-code scan FSM states and Kraft status.
package cr_xp10_decomp_pkg;

    // Longest Huffman code length supported by the HTF tables
    localparam int unsigned HtfMaxCodeLen = 27;

    // First-code scan controller states
    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StFin
    } htf_fcs_state_e;

    // Kraft status reported when a first-code scan finishes
    typedef struct packed {
        logic oversub;
        logic incomplete;
        logic empty;
    } htf_kraft_status_t;

endpackage

// File: rtl/cr_xp10_decomp_htf_first_code_scan.sv
// Canonical Huffman first-code scan over the HTF bit-length count array.
// Walks code lengths in ascending order, streams each length's first code
// through a valid/ready port and finishes with a Kraft status.
module cr_xp10_decomp_htf_first_code_scan
    import cr_xp10_decomp_pkg::*;
#(
    parameter int unsigned RANGE_BASE = 1,
    parameter int unsigned DEPTH      = 27,
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned CODE_W     = HtfMaxCodeLen,
    localparam int unsigned LEN_W     = $clog2(DEPTH + RANGE_BASE)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [DEPTH*WIDTH-1:0]   count_array_i,
    output logic                     busy_o,
    output logic                     fc_valid_o,
    input  logic                     fc_ready_i,
    output logic [LEN_W-1:0]         fc_len_o,
    output logic [CODE_W:0]          fc_data_o,
    output logic                     done_o,
    output logic                     oversub_o,
    output logic                     incomplete_o,
    output logic                     empty_o
);

    // Two spare bits so code + count can never wrap before the oversub test
    localparam int unsigned ACC_W = CODE_W + 2;
    localparam int unsigned MAX_LEN = DEPTH + RANGE_BASE - 1;
    localparam logic [LEN_W-1:0] BaseLen = LEN_W'(RANGE_BASE);
    localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(MAX_LEN);

    htf_fcs_state_e          state_q, state_d;
    logic [DEPTH*WIDTH-1:0]  snap_q, snap_d;
    logic                    busy_q, busy_d;
    logic                    fc_valid_q, fc_valid_d;
    logic [LEN_W-1:0]        fc_len_q, fc_len_d;
    logic [CODE_W:0]         fc_data_q, fc_data_d;
    logic                    done_q, done_d;
    htf_kraft_status_t       status_q, status_d;

    logic [WIDTH-1:0]        cur_count;
    logic [ACC_W-1:0]        acc_end;
    logic [ACC_W-1:0]        len_limit;
    logic                    over;
    logic                    at_max;
    logic                    xfer;
    logic                    all_zero;
    logic [CODE_W:0]         next_code;

    // Select the snapshot count for the length currently on the write port
    always_comb begin
        cur_count = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (fc_len_q == LEN_W'(j + RANGE_BASE)) begin
                cur_count = snap_q[j*WIDTH +: WIDTH];
            end
        end
    end

    // Kraft bookkeeping for the write being presented
    always_comb begin
        acc_end   = ACC_W'(fc_data_q) + ACC_W'(cur_count);
        len_limit = ACC_W'(1) << fc_len_q;
        over      = acc_end > len_limit;
        at_max    = fc_len_q == MaxLen;
        xfer      = fc_valid_q && fc_ready_i;
        all_zero  = ~|snap_q;
        // Only used when not over and not at max, so acc_end < 2^CODE_W here
        next_code = {acc_end[CODE_W-1:0], 1'b0};
    end

    // Next-state and registered-output logic of the scan controller
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        busy_d     = busy_q;
        fc_valid_d = fc_valid_q;
        fc_len_d   = fc_len_q;
        fc_data_d  = fc_data_q;
        done_d     = 1'b0;
        status_d   = status_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    snap_d     = count_array_i;
                    busy_d     = 1'b1;
                    // First length always starts at code 0
                    fc_valid_d = 1'b1;
                    fc_len_d   = BaseLen;
                    fc_data_d  = '0;
                    status_d   = '0;
                    state_d    = StScan;
                end
            end
            StScan: begin
                if (xfer) begin
                    if (over) begin
                        fc_valid_d       = 1'b0;
                        done_d           = 1'b1;
                        status_d.oversub = 1'b1;
                        state_d          = StFin;
                    end else if (at_max) begin
                        fc_valid_d          = 1'b0;
                        done_d              = 1'b1;
                        status_d.empty      = all_zero;
                        status_d.incomplete = !all_zero && (acc_end < len_limit);
                        state_d             = StFin;
                    end else begin
                        fc_len_d  = fc_len_q + LEN_W'(1);
                        fc_data_d = next_code;
                    end
                end
            end
            StFin: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            snap_q     <= '0;
            busy_q     <= 1'b0;
            fc_valid_q <= 1'b0;
            fc_len_q   <= '0;
            fc_data_q  <= '0;
            done_q     <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            fc_valid_q <= fc_valid_d;
            fc_len_q   <= fc_len_d;
            fc_data_q  <= fc_data_d;
            done_q     <= done_d;
            status_q   <= status_d;
        end
    end

    assign busy_o       = busy_q;
    assign fc_valid_o   = fc_valid_q;
    assign fc_len_o     = fc_len_q;
    assign fc_data_o    = fc_data_q;
    assign done_o       = done_q;
    assign oversub_o    = status_q.oversub;
    assign incomplete_o = status_q.incomplete;
    assign empty_o      = status_q.empty;

endmodule

// File: tb/tb_cr_xp10_decomp_htf_first_code_scan.sv
// Self-checking bench for the HTF first-code scan: directed table plus random counts.
module tb_cr_xp10_decomp_htf_first_code_scan;

    localparam int WIDTH = 10;
    localparam int DEPTH = 27;
    localparam int CAW   = DEPTH * WIDTH;
    localparam int MAXL  = 27;
    localparam int BUDGET = 400;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CAW-1:0]   count_array;
    logic             busy;
    logic             fc_valid;
    logic             fc_ready;
    logic [4:0]       fc_len;
    logic [27:0]      fc_data;
    logic             done;
    logic             oversub;
    logic             incomplete;
    logic             empty;

    int checks = 0;
    int errors = 0;

    int     exp_len[$];
    longint exp_data[$];

    typedef struct {
        logic [CAW-1:0] cv;
        int             mode;
        bit             perturb;
        bit             ov;
        bit             inc;
        bit             emp;
        int             writes;
        int             dcyc;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    cr_xp10_decomp_htf_first_code_scan dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .count_array_i  (count_array),
        .busy_o         (busy),
        .fc_valid_o     (fc_valid),
        .fc_ready_i     (fc_ready),
        .fc_len_o       (fc_len),
        .fc_data_o      (fc_data),
        .done_o         (done),
        .oversub_o      (oversub),
        .incomplete_o   (incomplete),
        .empty_o        (empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit ok, input string what, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", what, act, exp, $time);
        end
    endtask

    function automatic logic [CAW-1:0] mk(input int l0, input int v0, input int l1, input int v1,
                                          input int l2, input int v2);
        logic [CAW-1:0] r;
        r = '0;
        if (l0 > 0) r[(l0-1)*WIDTH +: WIDTH] = WIDTH'(v0);
        if (l1 > 0) r[(l1-1)*WIDTH +: WIDTH] = WIDTH'(v1);
        if (l2 > 0) r[(l2-1)*WIDTH +: WIDTH] = WIDTH'(v2);
        return r;
    endfunction

    function automatic longint cnt(input logic [CAW-1:0] v, input int l);
        return longint'(v[(l-1)*WIDTH +: WIDTH]);
    endfunction

    // Reference: first code of length L is the Kraft-weighted sum of all shorter codes
    task automatic model(input logic [CAW-1:0] v, output bit ov, output bit inc, output bit emp);
        longint first;
        longint fin;
        exp_len.delete();
        exp_data.delete();
        emp = (v == '0);
        ov  = 1'b0;
        inc = 1'b0;
        for (int l = 1; l <= MAXL; l++) begin
            first = 0;
            for (int k = 1; k < l; k++) first += cnt(v, k) << (l - k);
            exp_len.push_back(l);
            exp_data.push_back(first);
            fin = first + cnt(v, l);
            if (fin > (longint'(1) << l)) begin
                ov = 1'b1;
                break;
            end
            if (l == MAXL && !emp && fin < (longint'(1) << l)) inc = 1'b1;
        end
    endtask

    task automatic run_scan(input int id, input logic [CAW-1:0] cv, input int mode,
                            input bit perturb, input bit use_model, input bit e_ov_in,
                            input bit e_inc_in, input bit e_emp_in, input int e_writes_in,
                            input int e_dcyc);
        bit m_ov, m_inc, m_emp, e_ov, e_inc, e_emp, got_done;
        int e_writes, cyc, writes, stalls, want_cyc;
        logic [CAW-1:0] junk;
        model(cv, m_ov, m_inc, m_emp);
        e_ov = use_model ? m_ov : e_ov_in;
        e_inc = use_model ? m_inc : e_inc_in;
        e_emp = use_model ? m_emp : e_emp_in;
        e_writes = use_model ? exp_len.size() : e_writes_in;

        count_array = cv;
        fc_ready = 1'b0;
        start = 1'b1;
        chk(busy === 1'b0, $sformatf("scan%0d idle_busy", id), longint'(busy), 0);
        tick();
        start = 1'b0;
        cyc = 1;
        writes = 0;
        stalls = 0;
        got_done = 1'b0;
        while (!got_done && cyc < BUDGET) begin
            case (mode)
                1: fc_ready = 1'b1;
                2: fc_ready = (cyc % 4 == 1) || (cyc % 4 == 0);
                default: fc_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (perturb && cyc == 5) begin
                start = 1'b1;
                for (int j = 0; j < DEPTH; j++) junk[j*WIDTH +: WIDTH] = WIDTH'($urandom);
                count_array = junk;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                want_cyc = (e_dcyc >= 0) ? e_dcyc : writes + stalls + 1;
                chk(oversub === e_ov, $sformatf("scan%0d oversub", id), longint'(oversub), e_ov);
                chk(incomplete === e_inc, $sformatf("scan%0d incomplete", id),
                    longint'(incomplete), e_inc);
                chk(empty === e_emp, $sformatf("scan%0d empty", id), longint'(empty), e_emp);
                chk(writes == e_writes, $sformatf("scan%0d write_count", id), writes, e_writes);
                chk(cyc == want_cyc, $sformatf("scan%0d done_cycle", id), cyc, want_cyc);
                chk(fc_valid === 1'b0, $sformatf("scan%0d valid_at_done", id),
                    longint'(fc_valid), 0);
                chk(busy === 1'b1, $sformatf("scan%0d busy_at_done", id), longint'(busy), 1);
            end else begin
                chk(busy === 1'b1, $sformatf("scan%0d busy", id), longint'(busy), 1);
                if (fc_valid !== 1'b1) begin
                    chk(1'b0, $sformatf("scan%0d valid_in_scan c%0d", id, cyc),
                        longint'(fc_valid), 1);
                end else if (exp_len.size() == 0) begin
                    chk(1'b0, $sformatf("scan%0d extra_write", id), longint'(fc_len), 0);
                end else begin
                    chk(int'(fc_len) == exp_len[0], $sformatf("scan%0d fc_len c%0d", id, cyc),
                        longint'(fc_len), exp_len[0]);
                    chk(longint'(fc_data) == exp_data[0],
                        $sformatf("scan%0d fc_data len%0d", id, exp_len[0]),
                        longint'(fc_data), exp_data[0]);
                end
                if (fc_valid === 1'b1) begin
                    if (fc_ready) begin
                        writes++;
                        if (exp_len.size() > 0) begin
                            void'(exp_len.pop_front());
                            void'(exp_data.pop_front());
                        end
                    end else begin
                        stalls++;
                    end
                end
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        fc_ready = 1'b0;
        if (!got_done) chk(1'b0, $sformatf("scan%0d done_timeout", id), cyc, BUDGET);
        chk(busy === 1'b0, $sformatf("scan%0d busy_after", id), longint'(busy), 0);
        chk(done === 1'b0, $sformatf("scan%0d done_single", id), longint'(done), 0);
        chk(oversub === e_ov && incomplete === e_inc && empty === e_emp,
            $sformatf("scan%0d status_hold", id), {oversub, incomplete, empty},
            {e_ov, e_inc, e_emp});
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CAW-1:0] cv;
        logic [CAW-1:0] defl;
        int m;
        bit saw_done;

        defl = mk(2, 1, 3, 5, 4, 2);
        tbl[0] = '{defl,                   1, 1'b0, 1'b0, 1'b0, 1'b0, 27, 28};
        tbl[1] = '{mk(1, 3, 0, 0, 0, 0),   1, 1'b0, 1'b1, 1'b0, 1'b0, 1,  2};
        tbl[2] = '{mk(1, 1, 0, 0, 0, 0),   1, 1'b0, 1'b0, 1'b1, 1'b0, 27, 28};
        tbl[3] = '{mk(0, 0, 0, 0, 0, 0),   1, 1'b0, 1'b0, 1'b0, 1'b1, 27, 28};
        tbl[4] = '{defl,                   2, 1'b1, 1'b0, 1'b0, 1'b0, 27, 54};
        tbl[5] = '{mk(1, 2, 0, 0, 0, 0),   1, 1'b0, 1'b0, 1'b0, 1'b0, 27, 28};
        tbl[6] = '{mk(1, 2, 27, 1, 0, 0),  1, 1'b0, 1'b1, 1'b0, 1'b0, 27, 28};
        tbl[7] = '{mk(2, 4, 3, 1, 0, 0),   1, 1'b0, 1'b1, 1'b0, 1'b0, 3,  4};

        rst_n = 1'b0;
        start = 1'b0;
        fc_ready = 1'b0;
        count_array = '0;
        repeat (3) tick();
        chk(busy === 1'b0, "reset busy", longint'(busy), 0);
        chk(fc_valid === 1'b0, "reset fc_valid", longint'(fc_valid), 0);
        chk(fc_len === 5'd0, "reset fc_len", longint'(fc_len), 0);
        chk(fc_data === 28'd0, "reset fc_data", longint'(fc_data), 0);
        chk(done === 1'b0, "reset done", longint'(done), 0);
        chk(oversub === 1'b0, "reset oversub", longint'(oversub), 0);
        chk(incomplete === 1'b0, "reset incomplete", longint'(incomplete), 0);
        chk(empty === 1'b0, "reset empty", longint'(empty), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_scan(i, tbl[i].cv, tbl[i].mode, tbl[i].perturb, 1'b0, tbl[i].ov, tbl[i].inc,
                     tbl[i].emp, tbl[i].writes, tbl[i].dcyc);
        end

        // Reset at cycle 10 of a scan, then a clean rescan
        count_array = defl;
        start = 1'b1;
        tick();
        start = 1'b0;
        fc_ready = 1'b1;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        chk(fc_valid === 1'b0, "midreset fc_valid", longint'(fc_valid), 0);
        chk(busy === 1'b0, "midreset busy", longint'(busy), 0);
        chk(done === 1'b0, "midreset done", longint'(done), 0);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done === 1'b1 || fc_valid === 1'b1) saw_done = 1'b1;
        end
        chk(!saw_done, "midreset quiet_after", longint'(saw_done), 0);
        fc_ready = 1'b0;
        run_scan(100, defl, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 27, 28);

        // Random count arrays against the reference, random ready
        for (int r = 0; r < 40; r++) begin
            cv = '0;
            if (r % 8 != 0) begin
                m = $urandom_range(1, 10);
                for (int l = m; l <= MAXL; l++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        cv[(l-1)*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, (l - m < 3) ? 2 : 40));
                    end
                end
            end
            run_scan(200 + r, cv, 3, (r % 5 == 1), 1'b1, 1'b0, 1'b0, 1'b0, 0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
